demux1_to_4_stream: RTL and testbench

- Registered 1-to-4 stream demultiplexer with valid/ready handshake on every port.
- Routes each input word to one of four output lanes, chosen by the same two-bit select encoding the 4-to-1 mux uses: {s1,s0} = 00→lane0, 01→lane1, 10→lane2, 11→lane3.
- Sits on the receive side of a mux-based link: it fans a shared data path back out to four consumers.
- Each lane has a one-entry output register, so one lane stalling does not block the other lanes.

---
 rtl/demux1_to_4_stream.sv | 111 +++++++++++
 tb/tb_demux1_to_4_stream.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1_to_4_stream.sv
// 1:4 stream demux ({s1,s0} picks the lane), one output register per lane, 1 cycle from accept to out_valid.
// Backpressure: in_ready depends only on the selected lane (empty or draining); DEMUX_CNT_EN adds per-lane accept counters.
module demux1_to_4_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             idle
`ifdef DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_params
    $error("demux1_to_4_stream: WIDTH and CNT_W must be at least 1");
  end

  logic [1:0]            sel;
  logic                  accept;
  logic [3:0]            load;
  logic [3:0]            valid_q, valid_d;
  logic [3:0][WIDTH-1:0] data_q, data_d;

  assign sel = {s1, s0};

  // Reset forces not-ready so nothing can be accepted while lanes are being cleared.
  assign in_ready = reset_n & (~valid_q[sel] | out_ready[sel]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  // A load wins over a drain on the same edge, so a streaming lane keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int n = 0; n < 4; n++) begin
      if (load[n]) begin
        valid_d[n] = 1'b1;
        data_d[n]  = in_data;
      end else if (out_ready[n]) begin
        valid_d[n] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign idle      = ~|valid_q;

`ifdef DEMUX_CNT_EN
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counters wrap freely; they count accepted words, not drained ones.
  always_comb begin
    cnt_d = cnt_q;
    for (int n = 0; n < 4; n++) begin
      if (load[n]) begin
        cnt_d[n] = cnt_q[n] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux1_to_4_stream.sv
// Scoreboard bench for demux1_to_4_stream: per-lane expected queues filled on accept, drained by a negedge monitor.
module tb_demux1_to_4_stream;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s1, s0;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic       idle;
`ifdef DEMUX_CNT_EN
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  demux1_to_4_stream #(.WIDTH(8), .CNT_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s0        (s0),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .idle      (idle)
`ifdef DEMUX_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push(input int lane, input logic [7:0] d);
    case (lane)
      0: q0.push_back(d);
      1: q1.push_back(d);
      2: q2.push_back(d);
      default: q3.push_back(d);
    endcase
  endtask

  task automatic drive(input int lane, input logic [7:0] d, input logic v);
    logic [1:0] l;
    l        = lane[1:0];
    in_data  = d;
    s1       = l[1];
    s0       = l[0];
    in_valid = v;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer a word that must be accepted this cycle, then advance past the edge.
  task automatic send_now(input int lane, input logic [7:0] d, input string name);
    drive(lane, d, 1'b1);
    @(negedge clock);
    check(name, {31'b0, in_ready}, 32'd1);
    push(lane, d);
    tick();
  endtask

  // Monitor: a lane showing valid & ready at negedge transfers on the next edge.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int n = 0; n < 4; n++) begin
        if (out_valid[n] && out_ready[n]) begin
          logic [7:0] got;
          logic [7:0] exp;
          bit         have;
          have = 1'b0;
          exp  = 8'h00;
          case (n)
            0: begin got = out_data0; if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end end
            1: begin got = out_data1; if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end end
            2: begin got = out_data2; if (q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end end
            default: begin got = out_data3; if (q3.size() > 0) begin exp = q3.pop_front(); have = 1'b1; end end
          endcase
          n_cmp++;
          if (!have) begin
            n_fail++;
            $display("FAIL lane%0d_unexpected: got %0h expected nothing at %0t", n, got, $time);
          end else if (got !== exp) begin
            n_fail++;
            $display("FAIL lane%0d_data: got %0h expected %0h at %0t", n, got, exp, $time);
          end
        end
      end
    end
  end

  // Source protocol: a stalled offer must stay stable until accepted or withdrawn.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic [1:0] prev_sel   = 2'b00;
  always @(posedge clock) begin
    if (prev_stall && in_valid && (in_data !== prev_data || {s1, s0} !== prev_sel)) begin
      n_fail++;
      $display("FAIL src_protocol: got %0h/%0d expected %0h/%0d", in_data, {s1, s0}, prev_data, prev_sel);
    end
    prev_stall = in_valid & ~in_ready;
    prev_data  = in_data;
    prev_sel   = {s1, s0};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [4];
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F;

    reset_n   = 1'b0;
    out_ready = 4'b0000;
    drive(0, 8'h00, 1'b1);
    #3;
    check("rst_out_valid", {28'b0, out_valid}, 32'h0);
    check("rst_idle", {31'b0, idle}, 32'd1);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Routing: one word per lane on consecutive cycles.
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      send_now(i, words[i], "route_in_ready");
      check("route_out_valid", {28'b0, out_valid}, 32'h1 << i);
    end
    in_valid = 1'b0;
    tick();
    check("route_idle", {31'b0, idle}, 32'd1);

    // Stall isolation: lane1 blocked must not block lane2.
    out_ready = 4'b1101;
    send_now(1, 8'h11, "stall_first");
    drive(1, 8'h22, 1'b1);
    @(negedge clock);
    check("stall_not_ready_a", {31'b0, in_ready}, 32'd0);
    tick();
    @(negedge clock);
    check("stall_not_ready_b", {31'b0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    send_now(2, 8'h33, "stall_other_lane");
    check("stall_valid_mix", {28'b0, out_valid}, 32'h6);
    check("stall_hold_data1", {24'b0, out_data1}, 32'h11);
    drive(1, 8'h22, 1'b1);
    @(negedge clock);
    check("stall_not_ready_c", {31'b0, in_ready}, 32'd0);
    tick();
    out_ready = 4'b1111;
    @(negedge clock);
    check("stall_release_ready", {31'b0, in_ready}, 32'd1);
    push(1, 8'h22);
    tick();
    check("stall_replace_valid", {28'b0, out_valid}, 32'h2);
    check("stall_replace_data", {24'b0, out_data1}, 32'h22);
    in_valid = 1'b0;
    tick();
    check("stall_idle", {31'b0, idle}, 32'd1);

    // Back-to-back on lane0.
    for (int i = 0; i < 16; i++) begin
      send_now(0, 8'(i), "b2b_in_ready");
      check("b2b_valid0", {28'b0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    tick();
    check("b2b_idle", {31'b0, idle}, 32'd1);

    // Select toggling without valid changes nothing.
    for (int i = 0; i < 8; i++) begin
      drive(i % 4, 8'($urandom), 1'b0);
      tick();
      check("nosel_valid", {28'b0, out_valid}, 32'h0);
      check("nosel_idle", {31'b0, idle}, 32'd1);
    end

    // Reset mid-stream with lanes 1 and 3 holding words.
    out_ready = 4'b0101;
    send_now(1, 8'h5A, "mid_load1");
    send_now(3, 8'hC3, "mid_load3");
    check("mid_full", {28'b0, out_valid}, 32'hA);
    drive(1, 8'h77, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {28'b0, out_valid}, 32'h0);
    check("mid_rst_idle", {31'b0, idle}, 32'd1);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("mid_rst_data", {out_data3, out_data2, out_data1, out_data0}, 32'h0);
    q1.delete();
    q3.delete();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

`ifdef DEMUX_CNT_EN
    check("cnt_after_rst", {16'b0, cnt3, cnt2, cnt1, cnt0}, 32'h0);
    out_ready = 4'b1111;
    for (int i = 0; i < 17; i++) begin
      send_now(2, 8'(8'h40 + i), "cnt_in_ready");
    end
    in_valid = 1'b0;
    tick();
    check("cnt2_wrap", {28'b0, cnt2}, 32'd1);
    check("cnt_others", {20'b0, cnt3, cnt1, cnt0}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("cnt2_rst", {28'b0, cnt2}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
`endif

    tick();
    check("sb_empty", q0.size() + q1.size() + q2.size() + q3.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
